// File: rtl/mem_arbiter.sv
// Round-robin read-burst arbiter for the shared system-memory read port.
// Define MEM_ARB_PRIO0_EN to give requester 0 (display) strict priority.
module mem_arbiter #(
  parameter int AN = 24,
  parameter int DN = 16,
  parameter int N = 3,
  parameter int BURST = 8,
  localparam int OW = $clog2(N)
) (
  input  logic            clkSYS,
  input  logic            reset,
  input  logic [N*AN-1:0] req_addr,
  input  logic [N-1:0]    request,
  output logic [N-1:0]    req_ack,
  output logic [N-1:0]    mem_valid,
  output logic [DN-1:0]   mem_data,
  output logic [AN-1:0]   mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [DN-1:0]   mem_rdata,
  input  logic            mem_rvalid,
  output logic [OW-1:0]   owner,
  output logic            stray
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA
  } state_t;

  state_t          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_req_q;
  logic [AN-1:0]   mem_addr_q;
  logic            stray_q;

  logic [OW-1:0]   win_d;
  logic            hit_d;
  logic [OW-1:0]   rr_idx;
  logic [AN-1:0]   addr_d;
  logic [CW-1:0]   cnt_d;
  logic [N-1:0]    own_oh;

  // Search starts one past the last owner and wraps.
  always_comb begin
    win_d  = '0;
    hit_d  = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= N; i++) begin
      rr_idx = OW'((int'(last_q) + i) % N);
      if (!hit_d && request[rr_idx]) begin
        hit_d = 1'b1;
        win_d = rr_idx;
      end
    end
`ifdef MEM_ARB_PRIO0_EN
    if (request[0]) begin
      hit_d = 1'b1;
      win_d = '0;
    end
`endif
  end

  assign addr_d = req_addr[int'(win_d)*AN +: AN];
  assign cnt_d  = cnt_q + CW'(1);
  assign own_oh = {{(N-1){1'b0}}, 1'b1} << owner_q;

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= OW'(N - 1);
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      stray_q    <= 1'b0;
    end else begin
      if (mem_rvalid && state_q != DATA) begin
        stray_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (hit_d) begin
            owner_q    <= win_d;
            mem_addr_q <= addr_d;
            mem_req_q  <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            cnt_q <= cnt_d;
            if (cnt_q == LAST_BEAT) begin
              state_q <= IDLE;
`ifdef MEM_ARB_PRIO0_EN
              // Display bursts leave the rotation of the others untouched.
              if (owner_q != '0) begin
                last_q <= owner_q;
              end
`else
              last_q <= owner_q;
`endif
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack   = (state_q == ISSUE && mem_ack) ? own_oh : '0;
  assign mem_valid = (state_q == DATA && mem_rvalid) ? own_oh : '0;
  assign mem_data  = mem_rdata;
  assign mem_addr  = mem_addr_q;
  assign mem_req   = mem_req_q;
  assign owner     = owner_q;
  assign stray     = stray_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, corner sequences and a
// randomized run against a round-robin reference model.
module tb_mem_arbiter;

  localparam int AN = 24;
  localparam int DN = 16;
  localparam int N = 3;
  localparam int BURST = 8;
  localparam int OW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N*AN-1:0] req_addr;
  logic [N-1:0]    request;
  logic            mem_ack;
  logic [DN-1:0]   mem_rdata;
  logic            mem_rvalid;

  logic [N-1:0]  req_ack, mem_valid;
  logic [DN-1:0] mem_data;
  logic [AN-1:0] mem_addr;
  logic          mem_req, stray;
  logic [OW-1:0] owner;

  logic [N-1:0]  req_ack1, mem_valid1;
  logic [DN-1:0] mem_data1;
  logic [AN-1:0] mem_addr1;
  logic          mem_req1, stray1;
  logic [OW-1:0] owner1;

  mem_arbiter #(.AN(AN), .DN(DN), .N(N), .BURST(BURST)) u0 (
    .clkSYS(clk), .reset(reset), .req_addr(req_addr),
    .request(request), .req_ack(req_ack),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .owner(owner), .stray(stray)
  );

  mem_arbiter #(.AN(AN), .DN(DN), .N(N), .BURST(1)) u1 (
    .clkSYS(clk), .reset(reset), .req_addr(req_addr),
    .request(request), .req_ack(req_ack1),
    .mem_valid(mem_valid1), .mem_data(mem_data1),
    .mem_addr(mem_addr1), .mem_req(mem_req1), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .owner(owner1), .stray(stray1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] req;
    int dly;
    int exp_rr;
    int exp_p0;
  } vec_t;

  vec_t tbl[8];

  int last_m, exp_own, ack_wait, beats_left;
  bit idle_m, idle_pend, in_issue, ack_last;
  logic [N-1:0] req_edge, drop_m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i[OW-1:0]] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    int k;
`ifdef MEM_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int i = 1; i <= N; i++) begin
      k = (last + i) % N;
      if (r[k[OW-1:0]]) return k;
    end
    return -1;
  endfunction

  function automatic int next_last(input int last, input int own);
`ifdef MEM_ARB_PRIO0_EN
    if (own == 0) return last;
`endif
    return own;
  endfunction

  task automatic set_addr(input int k, input logic [AN-1:0] a);
    req_addr[k*AN +: AN] = a;
  endtask

  function automatic logic [AN-1:0] addr_of(input int k);
    return req_addr[k*AN +: AN];
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    request = '0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    step;
    step;
    reset = 1'b0;
  endtask

  // One complete burst for requester who, with a one-cycle data gap.
  task automatic run_burst(input int who, input int dly, input bit drop_all);
    int t;
    t = 0;
    while (mem_req !== 1'b1 && t < 8) begin
      step;
      t++;
    end
    if (mem_req !== 1'b1) begin
      chk("grant_timeout", {31'b0, mem_req}, 1);
      return;
    end
    chk("grant_addr", mem_addr, addr_of(who));
    chk("grant_owner", owner, who);
    for (int d = 0; d < dly; d++) begin
      #1 chk("ack_early", req_ack, 0);
      step;
      chk("req_held", mem_req, 1);
    end
    mem_ack = 1'b1;
    #1 chk("req_ack", req_ack, oh(who));
    step;
    mem_ack = 1'b0;
    if (drop_all) request = '0;
    chk("req_fall", mem_req, 0);
    for (int b = 0; b < BURST; b++) begin
      if (b == 2) begin
        mem_rvalid = 1'b0;
        #1 chk("gap_valid", mem_valid, 0);
        chk("ack_pulse", req_ack, 0);
        step;
      end
      mem_rvalid = 1'b1;
      mem_rdata = DN'($urandom);
      #1 chk("beat_valid", mem_valid, oh(who));
      chk("beat_data", mem_data, mem_rdata);
      step;
    end
    mem_rvalid = 1'b0;
    chk("b2b_gap", mem_req, 0);
    step;
    chk("b2b_req", mem_req, |request);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fair_rr[6];
    int fair_p0[6];
    req_addr = '0;
    tbl[0] = '{3'b010, 3, 1, 1};
    tbl[1] = '{3'b111, 0, 2, 0};
    tbl[2] = '{3'b111, 1, 0, 0};
    tbl[3] = '{3'b011, 2, 1, 0};
    tbl[4] = '{3'b101, 0, 2, 0};
    tbl[5] = '{3'b001, 1, 0, 0};
    tbl[6] = '{3'b110, 3, 1, 2};
    tbl[7] = '{3'b100, 0, 2, 2};
    fair_rr = '{0, 1, 2, 0, 1, 2};
    fair_p0 = '{0, 0, 0, 1, 2, 1};

    do_reset;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_stray", stray, 0);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        if (k == 1) set_addr(k, 24'h001000 + AN'(r) * 24'h010000);
        else set_addr(k, 24'h00A000 + AN'(r) * 24'h010000 + AN'(k) * 24'h100);
      end
      request = tbl[r].req;
`ifdef MEM_ARB_PRIO0_EN
      run_burst(tbl[r].exp_p0, tbl[r].dly, 1'b1);
`else
      run_burst(tbl[r].exp_rr, tbl[r].dly, 1'b1);
`endif
    end

    do_reset;
    set_addr(0, 24'h100000);
    set_addr(1, 24'h200000);
    set_addr(2, 24'h300000);
    request = 3'b111;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_PRIO0_EN
      if (i == 2) request = 3'b110;
      run_burst(fair_p0[i], 1, 1'b0);
`else
      run_burst(fair_rr[i], 1, 1'b0);
`endif
    end

    do_reset;
    mem_rvalid = 1'b1;
    mem_rdata = 16'h1234;
    #1 chk("stray_valid", mem_valid, 0);
    step;
    mem_rvalid = 1'b0;
    chk("stray_set", stray, 1);
    repeat (3) step;
    chk("stray_sticky", stray, 1);
    do_reset;
    chk("stray_clr", stray, 0);

    set_addr(1, 24'h00BEEF);
    request = 3'b010;
    for (int t = 0; t < 4 && mem_req !== 1'b1; t++) step;
    chk("mid_grant", mem_req, 1);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    request = '0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1;
      #1 chk("mid_beat", mem_valid, oh(1));
      step;
    end
    mem_rvalid = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("mid_req", mem_req, 0);
    chk("mid_owner", owner, 0);
    chk("mid_stray0", stray, 0);
    for (int b = 0; b < 5; b++) begin
      mem_rvalid = 1'b1;
      #1 chk("mid_drop", mem_valid, 0);
      step;
    end
    mem_rvalid = 1'b0;
    chk("mid_stray", stray, 1);

    do_reset;
    last_m = N - 1;
    idle_m = 1'b1;
    idle_pend = 1'b0;
    in_issue = 1'b0;
    ack_last = 1'b0;
    beats_left = 0;
    ack_wait = 0;
    exp_own = 0;
    req_edge = '0;
    drop_m = '0;
    for (int c = 0; c < 1500; c++) begin
      if (idle_m) begin
        chk("rnd_grant", mem_req, |req_edge);
        if (mem_req) begin
          exp_own = rr_pick(last_m, req_edge);
          chk("rnd_owner", owner, exp_own);
          chk("rnd_addr", mem_addr, addr_of(exp_own));
          idle_m = 1'b0;
          in_issue = 1'b1;
          ack_wait = $urandom_range(0, 3);
        end
      end else if (in_issue) begin
        chk("rnd_hold", mem_req, 1);
      end else if (ack_last) begin
        chk("rnd_fall", mem_req, 0);
      end
      if (idle_pend) begin
        idle_m = 1'b1;
        idle_pend = 1'b0;
      end
      request = request & ~drop_m;
      drop_m = '0;
      for (int k = 0; k < N; k++) begin
        if ((request & oh(k)) == '0 && $urandom_range(0, 3) == 0) begin
          request = request | oh(k);
          set_addr(k, AN'($urandom));
        end
      end
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      if (in_issue) begin
        if (ack_wait == 0) mem_ack = 1'b1;
        else ack_wait--;
      end else if (beats_left > 0 && $urandom_range(0, 2) != 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = DN'($urandom);
      end
      #1;
      chk("rnd_ack", req_ack, mem_ack ? oh(exp_own) : '0);
      chk("rnd_valid", mem_valid, mem_rvalid ? oh(exp_own) : '0);
      if (mem_rvalid) chk("rnd_data", mem_data, mem_rdata);
      ack_last = mem_ack;
      if (mem_ack) begin
        drop_m = oh(exp_own);
        in_issue = 1'b0;
        beats_left = BURST;
      end
      if (mem_rvalid) begin
        beats_left--;
        if (beats_left == 0) begin
          idle_pend = 1'b1;
          last_m = next_last(last_m, exp_own);
        end
      end
      req_edge = request;
      step;
    end
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    chk("rnd_stray", stray, 0);

    do_reset;
    set_addr(0, 24'h0A0A0A);
    set_addr(1, 24'h0B0B0B);
    set_addr(2, 24'h0C0C0C);
    request = 3'b100;
    for (int t = 0; t < 4 && mem_req1 !== 1'b1; t++) step;
    chk("w_grant", mem_req1, 1);
    chk("w_owner2", owner1, 2);
    mem_ack = 1'b1;
    #1 chk("w_ack", req_ack1, oh(2));
    step;
    mem_ack = 1'b0;
    request = '0;
    mem_rvalid = 1'b1;
    #1 chk("w_beat", mem_valid1, oh(2));
    step;
    mem_rvalid = 1'b0;
    request = 3'b011;
    chk("w_idle", mem_req1, 0);
    step;
    chk("w_req", mem_req1, 1);
    chk("w_owner0", owner1, 0);
    chk("w_addr", mem_addr1, 24'h0A0A0A);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    request = 3'b010;
    mem_rvalid = 1'b1;
    #1 chk("w_beat0", mem_valid1, oh(0));
    step;
    mem_rvalid = 1'b0;
    chk("w_idle2", mem_req1, 0);
    step;
    chk("w_req1", mem_req1, 1);
    chk("w_owner1", owner1, 1);
    chk("w_stray", stray1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
